// File: rtl/arb_pkg.sv
// Shared sizes and state encoding for the eight-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/onehot_dec8.sv
// 3-bit index to 8-bit one-hot decoder, all-zero when disabled.
// Combinational, no backpressure.
module onehot_dec8
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_onehot
);
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end
endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with hold limit; grant registered one cycle after request.
// Owner keeps the grant until it drops req, hits MAX_HOLD, or en falls; every release idles one cycle.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_id,
  output logic             grant_valid,
  output logic             timeout
);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  // Returns {found, index}: rotate so ptr sits at bit 0, take the lowest set bit, add ptr back.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W:0]     res;
    dbl = {r, r} >> p;
    rot = dbl[N_REQ-1:0];
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) res = {1'b1, p + IDX_W'(i)};
    end
    return res;
  endfunction

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [7:0]       r_hold;
  logic [N_REQ-1:0] r_grant;
  logic [IDX_W-1:0] r_grant_id;
  logic             r_grant_valid;
  logic             r_timeout;

  logic [IDX_W:0]   w_pick;
  logic             w_nxt_valid;
  logic [IDX_W-1:0] w_nxt_id;
  logic             w_load;
  logic             w_to;
  logic [N_REQ-1:0] w_dec;

  assign w_pick = rr_pick(req, r_ptr);

  always_comb begin
    w_nxt_valid = 1'b0;
    w_nxt_id    = r_grant_id;
    w_load      = 1'b0;
    w_to        = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && w_pick[IDX_W]) begin
          w_nxt_valid = 1'b1;
          w_nxt_id    = w_pick[IDX_W-1:0];
          w_load      = 1'b1;
        end
      end
      GRANT: begin
        if (!en || !req[r_grant_id]) begin
          w_nxt_valid = 1'b0;
        end else if (r_hold == HOLD_MAX) begin
          w_to = 1'b1;
        end else begin
          w_nxt_valid = 1'b1;
        end
      end
      default: w_nxt_valid = 1'b0;
    endcase
  end

  onehot_dec8 u_dec (
    .i_idx    (w_nxt_id),
    .i_en     (w_nxt_valid),
    .o_onehot (w_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_hold        <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_nxt_valid ? GRANT : IDLE;
      r_grant       <= w_dec;
      r_grant_id    <= w_nxt_id;
      r_grant_valid <= w_nxt_valid;
      r_timeout     <= w_to;
      if (w_load) begin
        r_ptr  <= w_nxt_id + 1'b1;
        r_hold <= 8'd1;
      end else if (w_nxt_valid) begin
        r_hold <= r_hold + 8'd1;
      end else begin
        r_hold <= '0;
      end
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic against a cycle-level
// model of the arbitration rules (owner index, search pointer, hold count as plain integers).
module tb_rr_arbiter_8;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_hold  = 0;
  logic m_to    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic [7:0] q);
    bit found;
    int j;
    m_to = 1'b0;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      found = 0;
      if (e && q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          j = (m_ptr + k) % 8;
          if (!found && q[j]) begin
            found   = 1;
            m_owner = j;
            m_ptr   = (j + 1) % 8;
            m_hold  = 1;
          end
        end
      end
    end else if (!e || !q[m_owner]) begin
      m_owner = -1;
    end else if (m_hold == MH) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input logic r, input logic e, input logic [7:0] q);
    logic [31:0] exp_g;
    rst = r;
    en  = e;
    req = q;
    @(posedge clk);
    model(r, e, q);
    #1;
    exp_g = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk("grant", 32'(grant), exp_g);
    chk("grant_valid", 32'(grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("timeout", 32'(timeout), 32'(m_to));
    if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
  endtask

  initial begin
    int         g3, to_at, ng;
    logic       prev_v;
    logic [7:0] q, rq;
    logic       rr, re;

    rst = 1'b1; en = 1'b0; req = 8'h00;

    // reset state
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_id", 32'(grant_id), 32'h0);

    // single request
    cyc(0, 1, 8'h04);
    chk("single_grant", 32'(grant), 32'h04);
    chk("single_id", 32'(grant_id), 32'd2);
    cyc(0, 1, 8'h04);
    cyc(0, 1, 8'h00);
    chk("single_drop", 32'(grant), 32'h0);

    // hold limit: 3 holds forever, 5 waiting
    cyc(1, 1, 8'h00);
    g3 = 0; to_at = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, 8'h28);
      if (grant == 8'h08) g3++;
      if (timeout) to_at = i;
    end
    chk("hold_cycles", 32'(g3), 32'd4);
    chk("hold_timeout_cycle", 32'(to_at), 32'd5);
    chk("hold_next_owner", 32'(grant), 32'h20);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);

    // rotation: everyone requests, owner drops after two cycles
    cyc(1, 1, 8'h00);
    ng = 0; prev_v = 1'b0;
    for (int i = 0; i < 60 && ng < 9; i++) begin
      q = 8'hFF;
      if (m_owner >= 0 && m_hold >= 2) q[m_owner] = 1'b0;
      cyc(0, 1, q);
      if (grant_valid && !prev_v) begin
        chk("rot_order", 32'(grant_id), 32'(ng % 8));
        ng++;
      end
      prev_v = grant_valid;
    end
    chk("rot_count", 32'(ng), 32'd9);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);

    // wrap from pointer 7
    cyc(0, 1, 8'h40);
    chk("wrap_pre", 32'(grant), 32'h40);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h41);
    chk("wrap_first", 32'(grant_id), 32'd0);
    cyc(0, 1, 8'h40);
    cyc(0, 1, 8'h40);
    chk("wrap_second", 32'(grant), 32'h40);
    cyc(0, 1, 8'h00);

    // reset mid-grant while 7 owns
    cyc(0, 1, 8'h80);
    chk("own7", 32'(grant), 32'h80);
    cyc(1, 1, 8'h80);
    chk("rst_mid_grant", 32'(grant), 32'h0);
    chk("rst_mid_valid", 32'(grant_valid), 32'h0);
    chk("rst_mid_id", 32'(grant_id), 32'h0);
    cyc(0, 1, 8'h81);
    chk("rst_then_0", 32'(grant), 32'h01);

    // reset with pointer away from 0 must restart the search at 0
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h08);
    cyc(1, 1, 8'h28);
    cyc(0, 1, 8'h28);
    chk("rst_ptr_clear", 32'(grant), 32'h08);

    // disable mid-grant, then no grants while disabled
    cyc(0, 0, 8'hFF);
    chk("dis_drop", 32'(grant), 32'h0);
    chk("dis_no_timeout", 32'(timeout), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 8'hFF);
      chk("dis_hold", 32'(grant_valid), 32'h0);
    end
    cyc(0, 1, 8'hFF);

    // random traffic
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      re = ($urandom_range(0, 15) != 0);
      case ($urandom_range(0, 7))
        0: rq = 8'($urandom);
        1: rq = rq | (8'd1 << $urandom_range(0, 7));
        2: if (m_owner >= 0) rq[m_owner] = 1'b0;
        3: rq = rq & 8'($urandom);
        default: ;
      endcase
      cyc(rr, re, rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares a single downstream resource (one select line per requester) between eight requesters. It picks one requester, drives a registered one-hot grant plus its 3-bit index, and holds the grant until the owner drops its request, the hold limit expires, or the block is disabled. The one-hot grant is produced by decoding the winning index, so the arbiter feeds the resource-select lines directly.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  arbitration enable; low blocks new grants and revokes any current grant.
- `req`  in  8  level request per requester; bit i is requester i.
- `grant`  out  8  registered one-hot grant, or all zero.
- `grant_id`  out  3  index of the current owner; valid only while `grant_valid` is high.
- `grant_valid`  out  1  high while any grant bit is set.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset values: `grant` = 8'h00, `grant_id` = 3'd0, `grant_valid` = 0, `timeout` = 0, state = IDLE, pointer `ptr` = 3'd0, hold counter = 0.
- **IDLE:**
  - If `en` = 1 and `req` ≠ 0, the winner is the first set `req` bit at or after `ptr`, searching upward and wrapping 7→0.
  - Go to GRANT. Set `grant_id` to the winner, `grant` to 1<<winner, `ptr` to winner+1 mod 8, hold counter to 1.
  - Otherwise stay in IDLE with `grant` = 0.
- **GRANT:** exits to IDLE and clears `grant`/`grant_valid` at the next edge, checking in this priority order:
  1. `en` = 0 forces release (no `timeout` pulse).
  2. `req[grant_id]` = 0 is a normal release.
  3. Hold counter = `MAX_HOLD` is a forced release; pulse `timeout` for one cycle.
  - Otherwise stay in GRANT and increment the hold counter.
- Every release passes through IDLE for at least one cycle, so there is always at least one all-zero `grant` cycle between owners.
- Because `ptr` already points past the previous owner, a timed-out owner cannot win again while any other requester is pending.
- Changes on `req` bits other than the owner's have no effect during GRANT.
- Hold counter is 8 bits wide and never wraps, because it exits at `MAX_HOLD`.
- `rst` mid-grant returns every output and `ptr` to its reset value at that edge, regardless of `en`/`req`.

## Timing
- Request to grant: `req` sampled in IDLE at edge N; `grant` is visible after edge N (one-cycle latency from the request asserting).
- Release to drop: owner deasserts `req` before edge M; `grant` reads 0 after edge M.
- The next grant appears after edge M+1.
- Maximum grant length is `MAX_HOLD` cycles. With all eight requesting continuously, each requester waits at most 7×(`MAX_HOLD`+1) cycles.
- `timeout` is asserted in the same cycle that `grant` first reads 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `arb_pkg` holds:
  - `N_REQ` = 8 and `IDX_W` = 3.
  - State enum `arb_state_t` {IDLE, GRANT}.
- One sub-module, `onehot_dec8`: 3-bit index plus enable in, 8-bit one-hot out, all-zero when disabled. It is combinational.
- The top-level registers the decoder's output into `grant`.
- Priority search is a rotate–find-first–unrotate function local to the top level.

## Test plan
- Single request: `req` = 8'h04 held, `en` = 1 after reset → `grant` = 8'h04, `grant_id` = 2 one cycle later; `req` dropped → `grant` = 0 next cycle.
- Rotation: `req` = 8'hFF, each owner releases after 2 cycles → grant order 0,1,2,…,7,0, with one idle cycle between owners.
- Wrap from pointer: after requester 6 is served, `req` = 8'h41 → requester 0 wins (search 7→0 wraps), then requester 6.
- Hold limit: `MAX_HOLD` = 4, requester 3 holds its request permanently, requester 5 also requesting → requester 3 is granted 4 cycles, then `timeout` pulses, then requester 5 is granted after the idle cycle.
- Disable: `en` driven 0 mid-grant → `grant` = 0 next edge, no `timeout` pulse; no new grant while `en` = 0 even with `req` = 8'hFF.
- Reset mid-grant: `rst` pulsed while requester 7 owns the grant → all outputs zero and `ptr` = 0 at that edge; with `req` = 8'h81 afterwards, requester 0 wins first.
